uart_rx_controller: RTL and testbench

Sequencing FSM for the UART receiver. It detects a falling edge on the line and runs an oversampling edge counter and a bit counter. It issues one-cycle enables to the receive datapath: sampler, start checker, deserializer, parity checker and stop checker. It reads back their registered error flags to accept or drop each frame, and it is the only block that decides frame boundaries and `data_valid`.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_edge_bit_counter.sv | 34 +++
 rtl/uart_rx_controller.sv | 132 +++++++++++++
 tb/tb_uart_rx_controller.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and strobe-offset helpers for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // The three majority samples straddle mid-bit; the check pulse follows right after.
  function automatic int SAMPLE_FIRST(input int prescale);
    return prescale / 2 - 1;
  endfunction

  function automatic int SAMPLE_LAST(input int prescale);
    return prescale / 2 + 1;
  endfunction

  function automatic int CHECK_EDGE(input int prescale);
    return prescale / 2 + 2;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and data-bit index counter for the UART receiver.
module uart_rx_edge_bit_counter #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          count_enable,
  input  logic                          bit_clear,
  input  logic                          bit_advance,
  output logic [$clog2(PRESCALE)-1:0]   edge_count,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_index
);

  localparam int EW = $clog2(PRESCALE);
  localparam logic [EW-1:0] LAST_EDGE = EW'(PRESCALE - 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      edge_count <= '0;
      bit_index  <= '0;
    end else begin
      // Explicit wrap keeps non-power-of-two prescales correct.
      if (!count_enable || edge_count == LAST_EDGE) edge_count <= '0;
      else                                          edge_count <= edge_count + 1'b1;

      if (bit_clear)        bit_index <= '0;
      else if (bit_advance) bit_index <= bit_index + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_controller.sv
// Frame sequencer for the UART receiver: start detection, per-bit strobes,
// frame accept/drop decisions.
module uart_rx_controller
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx_in,
  input  logic                          parity_enable,
  input  logic                          glitch,
  input  logic                          parity_error,
  input  logic                          stop_error,
  output logic                          sample_enable,
  output logic                          start_check_enable,
  output logic                          deser_enable,
  output logic                          parity_check_enable,
  output logic                          stop_check_enable,
  output logic [$clog2(PRESCALE)-1:0]   edge_count,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_index,
  output logic                          data_valid,
  output logic                          frame_error,
  output logic                          busy
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] SAMPLE_LO = EW'(SAMPLE_FIRST(PRESCALE));
  localparam logic [EW-1:0] SAMPLE_HI = EW'(SAMPLE_LAST(PRESCALE));
  localparam logic [EW-1:0] CHECK_AT  = EW'(CHECK_EDGE(PRESCALE));
  localparam logic [BW-1:0] FINAL_BIT = BW'(DATA_WIDTH - 1);

  rx_state_t state;
  logic      parity_latched;
  logic      last_edge;
  logic      final_bit;
  logic      count_enable;
  logic      bit_clear;
  logic      bit_advance;
  logic      check_edge;

  assign last_edge = (edge_count == LAST_EDGE);
  assign final_bit = (bit_index == FINAL_BIT);

  // The detect cycle is edge 0 of the start bit, so counting starts on it.
  assign count_enable = (state != IDLE) || !rx_in;
  assign bit_clear    = (state != DATA) || (last_edge && final_bit);
  assign bit_advance  = (state == DATA) && last_edge && !final_bit;
  assign busy         = (state != IDLE);

  uart_rx_edge_bit_counter #(
    .PRESCALE   (PRESCALE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_counter (
    .clock        (clock),
    .reset        (reset),
    .count_enable (count_enable),
    .bit_clear    (bit_clear),
    .bit_advance  (bit_advance),
    .edge_count   (edge_count),
    .bit_index    (bit_index)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      parity_latched <= 1'b0;
      data_valid     <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_in) begin
            state          <= START;
            parity_latched <= parity_enable;
          end
        end
        START: begin
          if (last_edge) state <= glitch ? IDLE : DATA;
        end
        DATA: begin
          if (last_edge && final_bit) state <= parity_latched ? PARITY : STOP;
        end
        PARITY: begin
          if (last_edge) begin
            if (parity_error) begin
              state       <= IDLE;
              frame_error <= 1'b1;
            end else begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (last_edge) begin
            state       <= IDLE;
            data_valid  <= !stop_error;
            frame_error <= stop_error;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output of this always_comb gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    sample_enable       = 1'b0;
    start_check_enable  = 1'b0;
    deser_enable        = 1'b0;
    parity_check_enable = 1'b0;
    stop_check_enable   = 1'b0;
    check_edge          = (edge_count == CHECK_AT);
    if (state != IDLE) begin
      sample_enable = (edge_count >= SAMPLE_LO) && (edge_count <= SAMPLE_HI);
      unique case (state)
        START:   start_check_enable  = check_edge;
        DATA:    deser_enable        = check_edge;
        PARITY:  parity_check_enable = check_edge;
        STOP:    stop_check_enable   = check_edge;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Randomized self-checking bench for uart_rx_controller with a cycle-level
// reference model built from slot/phase arithmetic and emulated checkers.
`timescale 1ns/1ps
module tb_uart_rx_controller;

  localparam int P  = 8;
  localparam int DW = 8;
  localparam int EW = $clog2(P);
  localparam int BW = $clog2(DW);
  localparam int DV = 13, FE = 12, BUSY = 11, SAMP = 10, SCE = 9, DE = 8, PCE = 7, STCE = 6;

  typedef struct packed {
    logic          par;
    logic          g;
    logic          pe_err;
    logic          se_err;
    logic [DW-1:0] data;
  } frame_t;

  typedef logic [13:0] obs_t;

  logic          clock = 1'b0;
  logic          reset, rx_in, parity_enable, glitch, parity_error, stop_error;
  logic          sample_enable, start_check_enable, deser_enable;
  logic          parity_check_enable, stop_check_enable;
  logic [EW-1:0] edge_count;
  logic [BW-1:0] bit_index;
  logic          data_valid, frame_error, busy;

  int   checks   = 0;
  int   failures = 0;
  obs_t obs_q[$];
  obs_t exp_q[$];
  logic pend_dv = 1'b0, pend_fe = 1'b0;
  logic q_g = 1'b0, q_pe = 1'b0, q_se = 1'b0;
  logic plan_g = 1'b0, plan_pe = 1'b0, plan_se = 1'b0;

  always #5 clock = ~clock;

  uart_rx_controller #(.PRESCALE(P), .DATA_WIDTH(DW)) dut (
    .clock               (clock),
    .reset               (reset),
    .rx_in               (rx_in),
    .parity_enable       (parity_enable),
    .glitch              (glitch),
    .parity_error        (parity_error),
    .stop_error          (stop_error),
    .sample_enable       (sample_enable),
    .start_check_enable  (start_check_enable),
    .deser_enable        (deser_enable),
    .parity_check_enable (parity_check_enable),
    .stop_check_enable   (stop_check_enable),
    .edge_count          (edge_count),
    .bit_index           (bit_index),
    .data_valid          (data_valid),
    .frame_error         (frame_error),
    .busy                (busy)
  );

  // One clock cycle: checker flags loaded by last cycle's pulses become visible,
  // outputs are sampled, inputs are driven, then the clock advances.
  task automatic tick(input logic rx, input logic pe, input logic rst, output obs_t obs);
    if (q_g)  glitch       = plan_g;
    if (q_pe) parity_error = plan_pe;
    if (q_se) stop_error   = plan_se;
    obs = {data_valid, frame_error, busy, sample_enable, start_check_enable, deser_enable,
           parity_check_enable, stop_check_enable, edge_count, bit_index};
    q_g  = start_check_enable;
    q_pe = parity_check_enable;
    q_se = stop_check_enable;
    rx_in         = rx;
    parity_enable = pe;
    reset         = rst;
    @(posedge clock);
    #1;
    if (rst) begin
      glitch = 1'b0; parity_error = 1'b0; stop_error = 1'b0;
      q_g = 1'b0; q_pe = 1'b0; q_se = 1'b0;
    end
  endtask

  // Expected outputs for cycle c of a frame (c=0 is the detect cycle).
  function automatic obs_t model_frame(input frame_t f, input int c);
    int   slot, ph;
    logic act, in_start, in_data, in_par, in_stop, samp, chk;
    logic [BW-1:0] bi;
    slot     = c / P;
    ph       = c % P;
    act      = (c >= 1);
    in_start = (slot == 0);
    in_data  = (slot >= 1) && (slot <= DW);
    in_par   = f.par && (slot == DW + 1);
    in_stop  = !in_start && !in_data && !in_par;
    samp     = act && (ph >= P / 2 - 1) && (ph <= P / 2 + 1);
    chk      = act && (ph == P / 2 + 2);
    bi       = in_data ? BW'(slot - 1) : '0;
    return {2'b00, act, samp, chk && in_start, chk && in_data, chk && in_par, chk && in_stop,
            EW'(ph), bi};
  endfunction

  function automatic logic line_level(input frame_t f, input int c);
    int   slot;
    logic lv;
    slot = c / P;
    if (f.g) return (c >= 2) ? 1'b1 : 1'b0;
    if (slot == 0) return 1'b0;
    if (slot <= DW)                     lv = f.data[slot-1];
    else if (f.par && slot == DW + 1)   lv = ^f.data;
    else                                lv = 1'b1;
    if ($urandom_range(15) == 0) lv = ~lv;
    return lv;
  endfunction

  task automatic idle(input int n);
    obs_t obs, exp;
    for (int i = 0; i < n; i++) begin
      exp = '0;
      exp[DV] = pend_dv;
      exp[FE] = pend_fe;
      pend_dv = 1'b0;
      pend_fe = 1'b0;
      tick(1'b1, 1'($urandom), 1'b0, obs);
      obs_q.push_back(obs);
      exp_q.push_back(exp);
    end
  endtask

  task automatic play_frame(input frame_t f, input int gap, input int abort_at);
    obs_t obs, exp;
    int   e;
    idle(gap);
    plan_g  = f.g;
    plan_pe = f.pe_err;
    plan_se = f.se_err;
    if (f.g)                    e = P;
    else if (f.par && f.pe_err) e = P * (2 + DW);
    else                        e = P * (2 + DW + (f.par ? 1 : 0));
    for (int c = 0; c < e; c++) begin
      exp = model_frame(f, c);
      if (c == 0) begin
        exp[DV] = pend_dv;
        exp[FE] = pend_fe;
        pend_dv = 1'b0;
        pend_fe = 1'b0;
      end
      tick(line_level(f, c), (c == 0) ? f.par : 1'($urandom), (c == abort_at) ? 1'b1 : 1'b0, obs);
      obs_q.push_back(obs);
      exp_q.push_back(exp);
      if (c == abort_at) return;
    end
    if (f.g) begin
      pend_dv = 1'b0; pend_fe = 1'b0;
    end else if (f.par && f.pe_err) begin
      pend_dv = 1'b0; pend_fe = 1'b1;
    end else begin
      pend_dv = !f.se_err; pend_fe = f.se_err;
    end
  endtask

  function automatic int count_bit(input int b);
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][b] === 1'b1) n++;
    return n;
  endfunction

  function automatic int nth_index(input int b, input int nth);
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][b] === 1'b1) begin
      if (n == nth) return i;
      n++;
    end
    return -1;
  endfunction

  task automatic begin_test();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    obs_t obs;
    begin_test();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, obs);
      checks++;
      if (obs !== obs_t'(0)) begin
        failures++;
        $display("FAIL reset_state tick %0d: got %h expected %h", i, obs, obs_t'(0));
      end
    end
  endtask

  task automatic test_parity_frame();
    frame_t f;
    f = '{par: 1'b1, g: 1'b0, pe_err: 1'b0, se_err: 1'b0, data: 8'hA5};
    begin_test();
    play_frame(f, 0, -1);
    idle(1);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL parity_frame cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (count_bit(DE) != DW) begin
      failures++; $display("FAIL parity_frame deser_count: got %0d expected %0d", count_bit(DE), DW);
    end
    checks++;
    if (nth_index(DV, 0) != 88 || count_bit(DV) != 1 || count_bit(FE) != 0) begin
      failures++;
      $display("FAIL parity_frame dv_cycle: got %0d (dv=%0d fe=%0d) expected 88 (1,0)",
               nth_index(DV, 0), count_bit(DV), count_bit(FE));
    end
  endtask

  task automatic test_no_parity();
    frame_t f;
    f = '{par: 1'b0, g: 1'b0, pe_err: 1'b0, se_err: 1'b0, data: 8'hA5};
    begin_test();
    play_frame(f, 2, -1);
    idle(1);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL no_parity cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (count_bit(PCE) != 0 || nth_index(DV, 0) != 2 + 80) begin
      failures++;
      $display("FAIL no_parity timing: pce=%0d dv_at=%0d expected pce=0 dv_at=82",
               count_bit(PCE), nth_index(DV, 0));
    end
  endtask

  task automatic test_glitch();
    frame_t f;
    f = '{par: 1'b1, g: 1'b1, pe_err: 1'b0, se_err: 1'b0, data: 8'h00};
    begin_test();
    play_frame(f, 1, -1);
    idle(3);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL glitch cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (count_bit(DE) != 0 || count_bit(DV) != 0 || count_bit(FE) != 0 || obs_q[1 + 8][BUSY] !== 1'b0) begin
      failures++;
      $display("FAIL glitch drop: de=%0d dv=%0d fe=%0d busy@8=%b expected 0 0 0 0",
               count_bit(DE), count_bit(DV), count_bit(FE), obs_q[1 + 8][BUSY]);
    end
  endtask

  task automatic test_error_frames();
    frame_t f;
    f = '{par: 1'b1, g: 1'b0, pe_err: 1'b1, se_err: 1'b0, data: 8'h3C};
    begin_test();
    play_frame(f, 0, -1);
    idle(2);
    f = '{par: 1'b1, g: 1'b0, pe_err: 1'b0, se_err: 1'b1, data: 8'hC3};
    play_frame(f, 0, -1);
    idle(1);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL error_frames cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (nth_index(FE, 0) != 80 || nth_index(STCE, 0) < 82 || count_bit(DV) != 0) begin
      failures++;
      $display("FAIL parity_error: fe_at=%0d first_stop_check=%0d dv=%0d expected 80 >=82 0",
               nth_index(FE, 0), nth_index(STCE, 0), count_bit(DV));
    end
    checks++;
    if (nth_index(FE, 1) != 82 + 88) begin
      failures++;
      $display("FAIL stop_error: fe_at=%0d expected %0d", nth_index(FE, 1), 82 + 88);
    end
  endtask

  task automatic test_back_to_back();
    frame_t f;
    begin_test();
    for (int k = 0; k < 2; k++) begin
      f = '{par: 1'b1, g: 1'b0, pe_err: 1'b0, se_err: 1'b0, data: DW'($urandom)};
      play_frame(f, 0, -1);
    end
    idle(1);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (nth_index(DV, 0) != 88 || nth_index(DV, 1) != 176 || obs_q[89][BUSY] !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back pulses: dv_at=%0d,%0d busy@89=%b expected 88,176 1",
               nth_index(DV, 0), nth_index(DV, 1), obs_q[89][BUSY]);
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_t f;
    begin_test();
    f = '{par: 1'b1, g: 1'b0, pe_err: 1'b0, se_err: 1'b0, data: 8'h5A};
    play_frame(f, 0, 40);
    pend_dv = 1'b0;
    pend_fe = 1'b0;
    idle(3);
    f = '{par: 1'b0, g: 1'b0, pe_err: 1'b0, se_err: 1'b0, data: 8'h96};
    play_frame(f, 0, -1);
    idle(1);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_mid_frame cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q[41] !== obs_t'(0) || count_bit(DV) != 1 || nth_index(DV, 0) != 44 + 80 || count_bit(FE) != 0) begin
      failures++;
      $display("FAIL reset_mid_frame recovery: c41=%h dv=%0d dv_at=%0d fe=%0d expected 0000 1 124 0",
               obs_q[41], count_bit(DV), nth_index(DV, 0), count_bit(FE));
    end
  endtask

  task automatic test_random();
    frame_t f;
    begin_test();
    for (int k = 0; k < 30; k++) begin
      f.par    = 1'($urandom);
      f.g      = ($urandom_range(5) == 0);
      f.pe_err = ($urandom_range(3) == 0);
      f.se_err = ($urandom_range(3) == 0);
      f.data   = DW'($urandom);
      play_frame(f, int'($urandom_range(3)), -1);
    end
    idle(2);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL random cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    rx_in         = 1'b0;
    parity_enable = 1'b0;
    glitch        = 1'b0;
    parity_error  = 1'b0;
    stop_error    = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_parity_frame();
    test_no_parity();
    test_glitch();
    test_error_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
